// File: rtl/cdc_req_arbiter.sv
// Round-robin arbiter funnelling REQ_CNT level requests onto one req/ack handshake channel.
// Optional wait-for-ack watchdog (timeout_o) is built only when CDC_ARB_TIMEOUT_EN is defined.
module cdc_req_arbiter #(
  parameter int REQ_CNT        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk_m_i,
  input  logic               rst_m_i,
  input  logic [REQ_CNT-1:0] req_i,
  output logic [REQ_CNT-1:0] grant_o,
  output logic [REQ_CNT-1:0] done_o,
  output logic               m_req_o,
  input  logic               m_ack_i,
  output logic               busy_o,
`ifdef CDC_ARB_TIMEOUT_EN
  output logic               timeout_o,
`endif
  output logic [1:0]         dbg_state_o
);

  // Handshake: a requester holds req_i high until its one-cycle done_o; toward the channel,
  // m_req_o is a single-cycle pulse and m_ack_i is a single-cycle strobe honoured only in WAIT.

  localparam int IDX_W = $clog2(REQ_CNT);
  localparam int CW    = IDX_W + 1;

  if (REQ_CNT < 2 || REQ_CNT > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("cdc_req_arbiter: unsupported parameter values");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [REQ_CNT-1:0] grant_q, grant_d;
  logic [REQ_CNT-1:0] done_q, done_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;

  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [CW-1:0]      cand;

  // Scan starts just after the last owner and wraps modulo REQ_CNT.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 1; i <= REQ_CNT; i++) begin
      cand = {1'b0, last_q} + CW'(i);
      if (cand >= CW'(REQ_CNT)) cand = cand - CW'(REQ_CNT);
      if (!win_found && req_i[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = ISSUE;
          owner_d          = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (m_ack_i) begin
          state_d = IDLE;
          grant_d = '0;
          done_d  = grant_q;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_m_i) begin
    if (rst_m_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(REQ_CNT - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign grant_o     = grant_q;
  assign done_o      = done_q;
  assign m_req_o     = (state_q == ISSUE);
  assign busy_o      = (state_q != IDLE);
  assign dbg_state_o = state_q;

`ifdef CDC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Counter saturates at the limit; the flag is informational and never forces WAIT to exit.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (state_q == ISSUE) begin
      cnt_d = '0;
    end else if (state_q == WAIT) begin
      if (m_ack_i) begin
        timeout_d = 1'b0;
      end else begin
        if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_m_i) begin
    if (rst_m_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_cdc_req_arbiter.sv
// Scoreboard bench for cdc_req_arbiter: driver predicts grants/dones from the round-robin rule,
// a negedge monitor pops and compares whenever the DUT issues m_req_o or done_o.
module tb_cdc_req_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] grant_o;
  logic [N-1:0] done_o;
  logic         m_req_o;
  logic         m_ack;
  logic         busy_o;
  logic [1:0]   dbg_state;
`ifdef CDC_ARB_TIMEOUT_EN
  logic         timeout_o;
`endif

  cdc_req_arbiter #(.REQ_CNT(N), .TIMEOUT_CYCLES(8)) dut (
    .clk_m_i     (clk),
    .rst_m_i     (rst),
    .req_i       (req),
    .grant_o     (grant_o),
    .done_o      (done_o),
    .m_req_o     (m_req_o),
    .m_ack_i     (m_ack),
`ifdef CDC_ARB_TIMEOUT_EN
    .timeout_o   (timeout_o),
`endif
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_done_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           mdl_last = N - 1;
  logic         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int i = 1; i <= N; i++) begin
      if (v[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // ---------------- monitor ----------------
  logic         prev_mreq = 1'b0;
  logic [N-1:0] cur_grant = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (m_req_o) begin
        check("no_back_to_back_mreq", {31'd0, prev_mreq}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_mreq", {31'd0, m_req_o}, 32'd0);
        end else begin
          cur_grant = exp_q.pop_front();
          check("grant", grant_o, cur_grant);
        end
      end else if (busy_o) begin
        check("grant_hold", grant_o, cur_grant);
      end else begin
        check("grant_idle", grant_o, 32'd0);
      end
      if (done_o != '0) begin
        if (exp_done_q.size() == 0) check("unexpected_done", done_o, 32'd0);
        else check("done", done_o, exp_done_q.pop_front());
      end
      prev_mreq = m_req_o;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge while the DUT is idle; vec must be non-zero.
  task automatic run_xfer(input logic [N-1:0] vec, input int ack_dly,
                          input bit spur_issue_ack, input bit drop_owner);
    int w;
    int lat;
    req = vec;
    w   = rr_pick(vec, mdl_last);
    exp_q.push_back(onehot(w));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_req_o && lat < 8);
    check("req_latency", lat, 1);
    if (spur_issue_ack) m_ack = 1'b1;
    for (int k = 1; k <= ack_dly; k++) begin
      @(negedge clk);
      m_ack = 1'b0;
      check("busy_in_wait", {31'd0, busy_o}, 32'd1);
      if (drop_owner && k == 1) req[w] = 1'b0;
      if (k == ack_dly) begin
        m_ack = 1'b1;
        exp_done_q.push_back(onehot(w));
        mdl_last = w;
      end
    end
    @(negedge clk);
    m_ack = 1'b0;
    check("busy_after_done", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic idle_spurious_ack();
    req   = '0;
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    check("idle_ack_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    check("idle_ack_busy2", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic reset_in_wait(input logic [N-1:0] vec);
    int w;
    req = vec;
    w   = rr_pick(vec, mdl_last);
    exp_q.push_back(onehot(w));
    @(negedge clk);
    check("rst_test_mreq", {31'd0, m_req_o}, 32'd1);
    @(negedge clk);
    check("rst_test_in_wait", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    mdl_last = N - 1;
    check("rst_mid_grant", grant_o, 32'd0);
    check("rst_mid_done", done_o, 32'd0);
    check("rst_mid_mreq", {31'd0, m_req_o}, 32'd0);
    check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
  endtask

`ifdef CDC_ARB_TIMEOUT_EN
  task automatic timeout_test();
    int lat;
    req = 4'b0001;
    exp_q.push_back(onehot(rr_pick(req, mdl_last)));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_req_o && lat < 8);
    check("to_latency", lat, 1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 8)  check("timeout_before", {31'd0, timeout_o}, 32'd0);
      if (k == 9)  check("timeout_set", {31'd0, timeout_o}, 32'd1);
      if (k == 20) begin
        check("timeout_sticky", {31'd0, timeout_o}, 32'd1);
        m_ack = 1'b1;
        exp_done_q.push_back(4'b0001);
        mdl_last = 0;
      end
    end
    @(negedge clk);
    m_ack = 1'b0;
    check("timeout_cleared", {31'd0, timeout_o}, 32'd0);
    req = '0;
    @(negedge clk);
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] v;
    rst   = 1'b1;
    req   = '0;
    m_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_grant", grant_o, 32'd0);
    check("reset_done", done_o, 32'd0);
    check("reset_mreq", {31'd0, m_req_o}, 32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
`ifdef CDC_ARB_TIMEOUT_EN
    check("reset_timeout", {31'd0, timeout_o}, 32'd0);
`endif
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // single requester, ack five cycles after m_req_o
    run_xfer(4'b0001, 5, 1'b0, 1'b0);
    req = '0;
    @(negedge clk);

    // all requesters held high: rotation 0,1,2,3,0 after a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    mdl_last = N - 1;
    for (int t = 0; t < 5; t++) run_xfer(4'b1111, 3, 1'b0, 1'b0);
    req = '0;
    @(negedge clk);

    // wrap-around: grant to 2 then 0101 goes to 0
    run_xfer(4'b0100, 2, 1'b0, 1'b0);
    run_xfer(4'b0101, 2, 1'b0, 1'b0);
    req = '0;
    @(negedge clk);

    // ignored acks in IDLE and ISSUE, owner dropping in WAIT
    idle_spurious_ack();
    run_xfer(4'b0010, 4, 1'b1, 1'b0);
    run_xfer(4'b1000, 3, 1'b0, 1'b1);
    req = '0;
    @(negedge clk);

    // reset mid-transfer restores index 0 priority
    run_xfer(4'b0001, 1, 1'b0, 1'b0);
    reset_in_wait(4'b0001);
    run_xfer(4'b1111, 2, 1'b0, 1'b0);

`ifdef CDC_ARB_TIMEOUT_EN
    req = '0;
    @(negedge clk);
    timeout_test();
`endif

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      v = N'($urandom_range(1, (1 << N) - 1));
      run_xfer(v, $urandom_range(1, 6), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) idle_spurious_ack();
    end

    req = '0;
    repeat (3) @(negedge clk);
    check("grant_queue_drained", exp_q.size(), 32'd0);
    check("done_queue_drained", exp_done_q.size(), 32'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_req_arbiter.md
CDC_REQ_ARBITER -- requirements
Module: cdc_req_arbiter

Interface
REQ-001 Parameter REQ_CNT, default 4, number of requesters sharing one handshake channel (range 2..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, wait-for-ack cycle limit; used only under CDC_ARB_TIMEOUT_EN.
REQ-003 Port clk_m_i  input  1  master-domain clock; single clock, all logic on its rising edge.
REQ-004 Port rst_m_i  input  1  reset, synchronous, active-high.
REQ-005 Port req_i  input  REQ_CNT  per-requester level request, held high until its done_o pulse.
REQ-006 Port grant_o  output  REQ_CNT  one-hot, registered; the owner of the in-flight transfer.
REQ-007 Port done_o  output  REQ_CNT  one-cycle pulse to the owner when its transfer is acknowledged.
REQ-008 Port m_req_o  output  1  one-cycle request pulse to the handshake channel master side.
REQ-009 Port m_ack_i  input  1  one-cycle acknowledge strobe from the handshake channel master side.
REQ-010 Port busy_o  output  1  high while in ISSUE or WAIT.
REQ-011 Port timeout_o  output  1  sticky wait-limit flag; present only under CDC_ARB_TIMEOUT_EN.

Function
REQ-012 FSM states IDLE, ISSUE, WAIT; IDLE->ISSUE when any req_i bit is high; ISSUE->WAIT unconditionally; WAIT->IDLE on m_ack_i.
REQ-013 Winner selection is round-robin: search starts at index (last_grant+1) mod REQ_CNT, first high req_i bit wins; after reset last_grant = REQ_CNT-1, so index 0 has first priority.
REQ-014 Winner index is latched on the IDLE->ISSUE edge; grant_o goes one-hot on the next cycle and holds through ISSUE and WAIT.
REQ-015 m_req_o is high exactly during the ISSUE cycle; latency from req_i sampled in IDLE to m_req_o is 1 cycle.
REQ-016 On m_ack_i in WAIT: done_o[owner] pulses in the next cycle, grant_o clears, last_grant = owner, and the state returns to IDLE.
REQ-017 The minimum turnaround is one IDLE cycle after done_o before the next ISSUE; no back-to-back m_req_o pulses occur.
REQ-018 m_ack_i in IDLE or ISSUE is ignored and has no effect on any output.
REQ-019 req_i of the owner dropping during ISSUE/WAIT does not abort; the transfer completes and done_o still pulses.
REQ-020 req_i changes of non-owners during ISSUE/WAIT have no effect until the next IDLE arbitration.
REQ-021 With all requesters permanently high, grants rotate 0,1,2,...,REQ_CNT-1,0.

Reset
REQ-022 rst_m_i high at a clock edge forces IDLE, grant_o=0, done_o=0, m_req_o=0, busy_o=0, timeout_o=0, last_grant=REQ_CNT-1.
REQ-023 Reset mid-transfer discards the owner with no done_o; the handshake channel is reset by the same rst_m_i.

Configuration
REQ-024 With macro CDC_ARB_TIMEOUT_EN defined: a wait counter clears on entering WAIT and increments each WAIT cycle; when it reaches TIMEOUT_CYCLES, timeout_o sets and stays high.
REQ-025 Under CDC_ARB_TIMEOUT_EN, timeout_o clears only on reset or on the m_ack_i that ends the transfer; the FSM never abandons WAIT because of a timeout.
REQ-026 Without CDC_ARB_TIMEOUT_EN: no counter and no timeout_o port; all other behaviour is identical.

Verification
REQ-027 Reset, then req_i=4'b0001 -> m_req_o pulses 1 cycle later, grant_o=0001; m_ack_i 5 cycles later -> done_o=0001 the next cycle, busy_o=0.
REQ-028 req_i=4'b1111 held, ack 3 cycles after each m_req_o -> grant order 0,1,2,3,0; exactly one m_req_o per grant.
REQ-029 After grant to 2 completes, req_i=4'b0101 -> next grant is 0 (wrap-around), not 2.
REQ-030 m_ack_i pulsed in IDLE and during ISSUE -> no done_o, state unaffected; a later ack in WAIT completes normally.
REQ-031 Owner drops req_i in WAIT -> transfer still completes with done_o; rst_m_i asserted in WAIT -> all outputs 0 next cycle, no done_o.
REQ-032 CDC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack withheld -> timeout_o high after 8 WAIT cycles and remains high; ack at cycle 20 -> done_o pulses and timeout_o clears.
